// File: rtl/instr_sequencer_pkg.sv
// Shared constants, state/instruction-kind encodings and the Moore output map
// for the Simple RISC Machine instruction sequencer.
package instr_sequencer_pkg;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S_WAIT   = 4'd0,
    S_DECODE = 4'd1,
    S_WR_IMM = 4'd2,
    S_GET_A  = 4'd3,
    S_GET_B  = 4'd4,
    S_ALU    = 4'd5,
    S_WR_REG = 4'd6
  } state_t;

  // Latched in DECODE so the ALU state knows which variant it is running.
  typedef enum logic [1:0] {K_ALU, K_CMP, K_MOV} kind_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM  = 2'b10;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
  } ctrl_out_t;

  function automatic ctrl_out_t state_outs(state_t st, kind_t k);
    ctrl_out_t o;
    o = '0;
    case (st)
      S_WAIT:   o.w = 1'b1;
      S_WR_IMM: begin o.nsel = NSEL_RN; o.vsel = VSEL_IMM; o.write = 1'b1; end
      S_GET_A:  begin o.nsel = NSEL_RN; o.loada = 1'b1; end
      S_GET_B:  begin o.nsel = NSEL_RM; o.loadb = 1'b1; end
      S_ALU: begin
        o.loads = (k == K_CMP);
        o.loadc = (k != K_CMP);
        o.asel  = (k == K_MOV);
      end
      S_WR_REG: begin o.nsel = NSEL_RD; o.vsel = VSEL_C; o.write = 1'b1; end
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer bus: instruction-register inputs in, datapath control strobes out.
interface instr_sequencer_if #(parameter int VSEL_W = 2);
  logic              s;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic              w;
  logic [2:0]        nsel;
  logic [VSEL_W-1:0] vsel;
  logic              write;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic              illegal;

  modport master (output s, opcode, op,
                  input  w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal);
  modport slave  (input  s, opcode, op,
                  output w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal);
endinterface

// File: rtl/instr_sequencer_ctrl_decode.sv
// Combinational map from {opcode,op} to the state following DECODE,
// the instruction kind used by ALU, and the unsupported-pair flag.
module ctrl_decode
  import instr_sequencer_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output state_t     next,
  output kind_t      kind,
  output logic       illegal
);
  always_comb begin
    next    = S_WAIT;
    kind    = K_ALU;
    illegal = 1'b0;
    case ({opcode, op})
      {OPC_MOV, OP_MOV_IMM}: next = S_WR_IMM;
      {OPC_MOV, OP_MOV_REG}: begin next = S_GET_B; kind = K_MOV; end
      {OPC_ALU, OP_MVN}:     next = S_GET_B;
      {OPC_ALU, OP_ADD},
      {OPC_ALU, OP_AND}:     next = S_GET_A;
      {OPC_ALU, OP_CMP}:     begin next = S_GET_A; kind = K_CMP; end
      default:               illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_sequencer.sv
// Moore controller: steps the datapath through one instruction per start
// request; outputs are registered from the next state.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int VSEL_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.slave   bus
);
  if (STATE_W != ST_W) begin : g_bad_state_w
    $error("instr_sequencer: STATE_W must match the package state encoding");
  end

  state_t    state, nxt, dec_next;
  kind_t     kind, kind_nxt, dec_kind;
  logic      dec_illegal;
  ctrl_out_t outs;

  ctrl_decode u_decode (
    .opcode  (bus.opcode),
    .op      (bus.op),
    .next    (dec_next),
    .kind    (dec_kind),
    .illegal (dec_illegal)
  );

  always_comb begin
    nxt      = S_WAIT;
    kind_nxt = (state == S_DECODE) ? dec_kind : kind;
    case (state)
      S_WAIT:   nxt = bus.s ? S_DECODE : S_WAIT;
      S_DECODE: nxt = dec_next;
      S_GET_A:  nxt = S_GET_B;
      S_GET_B:  nxt = S_ALU;
      S_ALU:    nxt = (kind == K_CMP) ? S_WAIT : S_WR_REG;
      default:  nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      kind  <= K_ALU;
      outs  <= state_outs(S_WAIT, K_ALU);
    end else begin
      state <= nxt;
      kind  <= kind_nxt;
      outs  <= state_outs(nxt, kind_nxt);
    end
  end

  // An instruction abandoned by reset must not commit a register or flag write.
  assign bus.w       = outs.w;
  assign bus.nsel    = outs.nsel;
  assign bus.vsel    = VSEL_W'(outs.vsel);
  assign bus.write   = outs.write & ~reset;
  assign bus.loads   = outs.loads & ~reset;
  assign bus.loada   = outs.loada;
  assign bus.loadb   = outs.loadb;
  assign bus.loadc   = outs.loadc;
  assign bus.asel    = outs.asel;
  assign bus.bsel    = 1'b0;
  assign bus.illegal = (state == S_DECODE) & dec_illegal;

endmodule
